// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pc_fetch_ctrl_if : redirect/stall inputs and fetch-state outputs
// Rev 1.0
// ------------------------------------------------------------------
interface pc_fetch_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             stall;
   logic             redirect;
   logic             jalrsel;
   logic [XLEN-1:0]  ex_PC;
   logic [XLEN-1:0]  base;
   logic [XLEN-1:0]  ImmOp;
   logic [XLEN-1:0]  PC;
   logic [XLEN-1:0]  PC_D;
   logic             valid_D;
   logic             misaligned;
   logic [XLEN-1:0]  bad_addr;
   logic [CNT_W-1:0] redirect_cnt;

   modport master (
      output stall, redirect, jalrsel, ex_PC, base, ImmOp,
      input  PC, PC_D, valid_D, misaligned, bad_addr, redirect_cnt
   );

   modport slave (
      input  stall, redirect, jalrsel, ex_PC, base, ImmOp,
      output PC, PC_D, valid_D, misaligned, bad_addr, redirect_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// pc_fetch_ctrl : fetch PC generator with redirect, stall and trap diversion
// Rev 1.0
// ------------------------------------------------------------------
module pc_fetch_ctrl #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0000_0100,
   parameter int              CNT_W        = 16
) (
   input wire             clk,
   input wire             rst,
   pc_fetch_ctrl_if.slave bus
);

   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_d;
   logic             valid_d;
   logic             mis;
   logic [XLEN-1:0]  bad;
   logic [CNT_W-1:0] cnt;

   logic [XLEN-1:0]  sum;
   logic [XLEN-1:0]  target;
   logic             target_mis;

   // JALR clears bit 0 before the alignment check, so only bit 1 can fault there
   always_comb begin
      sum        = bus.jalrsel ? (bus.base + bus.ImmOp) : (bus.ex_PC + bus.ImmOp);
      target     = sum;
      if (bus.jalrsel) target[0] = 1'b0;
      target_mis = |target[1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_VECTOR;
         pc_d    <= '0;
         valid_d <= 1'b0;
         mis     <= 1'b0;
         bad     <= '0;
         cnt     <= '0;
      end else if (bus.redirect) begin
         valid_d <= 1'b0;
         if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
         if (target_mis) begin
            pc  <= TRAP_VECTOR;
            mis <= 1'b1;
            bad <= target;
         end else begin
            pc  <= target;
            mis <= 1'b0;
         end
      end else if (bus.stall) begin
         mis <= 1'b0;
      end else begin
         pc      <= pc + XLEN'(4);
         pc_d    <= pc;
         valid_d <= 1'b1;
         mis     <= 1'b0;
      end
   end

   assign bus.PC           = pc;
   assign bus.PC_D         = pc_d;
   assign bus.valid_D      = valid_d;
   assign bus.misaligned   = mis;
   assign bus.bad_addr     = bad;
   assign bus.redirect_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pc_fetch_ctrl : directed + random check of two pc_fetch_ctrl instances
// Rev 1.0
// ------------------------------------------------------------------
module tb_pc_fetch_ctrl;
   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, stall = 1'b0, redirect = 1'b0, jalrsel = 1'b0;
   logic [31:0] ex_PC = '0, base = '0, ImmOp = '0;
   int total = 0;
   int bad   = 0;

   pc_fetch_ctrl_if #(.XLEN(32), .CNT_W(16)) bus_a ();
   pc_fetch_ctrl_if #(.XLEN(32), .CNT_W(2))  bus_b ();

   assign bus_a.stall = stall;  assign bus_a.redirect = redirect;  assign bus_a.jalrsel = jalrsel;
   assign bus_a.ex_PC = ex_PC;  assign bus_a.base = base;          assign bus_a.ImmOp = ImmOp;
   assign bus_b.stall = stall;  assign bus_b.redirect = redirect;  assign bus_b.jalrsel = jalrsel;
   assign bus_b.ex_PC = ex_PC;  assign bus_b.base = base;          assign bus_b.ImmOp = ImmOp;

   pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(16))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(2))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the architectural effect of each sampled edge
   logic [31:0] m_pc, m_pcd, m_bad;
   bit          m_vd, m_mis, m_init = 1'b0;
   int          m_cnt_a, m_cnt_b;

   function automatic logic [31:0] tgt(input logic js, input logic [31:0] ep, b, im);
      return js ? ((b + im) & 32'hFFFF_FFFE) : (ep + im);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_pc <= RV; m_pcd <= '0; m_vd <= 1'b0; m_mis <= 1'b0; m_bad <= '0;
         m_cnt_a <= 0; m_cnt_b <= 0; m_init <= 1'b1;
      end else if (redirect) begin
         m_vd    <= 1'b0;
         m_cnt_a <= (m_cnt_a < 65535) ? m_cnt_a + 1 : m_cnt_a;
         m_cnt_b <= (m_cnt_b < 3) ? m_cnt_b + 1 : m_cnt_b;
         if (tgt(jalrsel, ex_PC, base, ImmOp) % 4 != 0) begin
            m_pc <= TV; m_mis <= 1'b1; m_bad <= tgt(jalrsel, ex_PC, base, ImmOp);
         end else begin
            m_pc <= tgt(jalrsel, ex_PC, base, ImmOp); m_mis <= 1'b0;
         end
      end else if (stall) begin
         m_mis <= 1'b0;
      end else begin
         m_pc <= m_pc + 32'd4; m_pcd <= m_pc; m_vd <= 1'b1; m_mis <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("pc_a",   bus_a.PC,           m_pc);
         chk("pcd_a",  bus_a.PC_D,         m_pcd);
         chk("vd_a",   32'(bus_a.valid_D),    32'(m_vd));
         chk("mis_a",  32'(bus_a.misaligned), 32'(m_mis));
         chk("bad_a",  bus_a.bad_addr,     m_bad);
         chk("cnt_a",  32'(bus_a.redirect_cnt), m_cnt_a);
         chk("pc_b",   bus_b.PC,           m_pc);
         chk("mis_b",  32'(bus_b.misaligned), 32'(m_mis));
         chk("cnt_b",  32'(bus_b.redirect_cnt), m_cnt_b);
      end
   end

   task automatic drive(input bit r, st, rd, js, input logic [31:0] ep, b, im);
      rst = r; stall = st; redirect = rd; jalrsel = js; ex_PC = ep; base = b; ImmOp = im;
      @(negedge clk);
   endtask

   int exp_b[5] = '{1, 2, 3, 3, 3};

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("lit_rst_pc", bus_a.PC, 32'h0);
      chk("lit_rst_vd", 32'(bus_a.valid_D), 32'd0);

      // Free run after reset release
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         chk("lit_run_pc",  bus_a.PC,   32'(4 * i));
         chk("lit_run_pcd", bus_a.PC_D, 32'(4 * (i - 1)));
         chk("lit_run_vd",  32'(bus_a.valid_D), 32'd1);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0, 0, 0);
         chk("lit_stall_pc", bus_a.PC, 32'h10);
      end
      drive(0, 1, 1, 0, 32'hC, 0, 32'h40);
      chk("lit_redir_pc",  bus_a.PC, 32'h4C);
      chk("lit_redir_vd",  32'(bus_a.valid_D), 32'd0);
      chk("lit_redir_cnt", 32'(bus_a.redirect_cnt), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("lit_post_pc",  bus_a.PC,   32'h50);
      chk("lit_post_pcd", bus_a.PC_D, 32'h4C);

      // JALR misaligned then bit-0-only JALR
      drive(0, 0, 1, 1, 0, 32'h1001, 32'h2);
      chk("lit_trap_pc",  bus_a.PC, 32'h100);
      chk("lit_trap_mis", 32'(bus_a.misaligned), 32'd1);
      chk("lit_trap_bad", bus_a.bad_addr, 32'h1002);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("lit_trap_pulse", 32'(bus_a.misaligned), 32'd0);
      chk("lit_bad_hold",   bus_a.bad_addr, 32'h1002);
      drive(0, 0, 1, 1, 0, 32'h2001, 32'h0);
      chk("lit_jalr_pc",  bus_a.PC, 32'h2000);
      chk("lit_jalr_mis", 32'(bus_a.misaligned), 32'd0);

      // PC wrap
      drive(0, 0, 1, 0, 32'hFFFF_FFF0, 0, 32'hC);
      chk("lit_top_pc", bus_a.PC, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("lit_wrap_pc",  bus_a.PC,   32'h0);
      chk("lit_wrap_pcd", bus_a.PC_D, 32'hFFFF_FFFC);

      // Saturation of the 2-bit counter
      drive(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1, 0, 32'h200, 0, 32'h0);
         chk("lit_sat_b", 32'(bus_b.redirect_cnt), 32'(exp_b[i]));
         chk("lit_sat_a", 32'(bus_a.redirect_cnt), 32'(i + 1));
      end

      // Back-to-back faulting redirects
      drive(0, 0, 1, 0, 32'h10, 0, 32'h2);
      chk("lit_b2b_mis1", 32'(bus_a.misaligned), 32'd1);
      chk("lit_b2b_bad1", bus_a.bad_addr, 32'h12);
      drive(0, 0, 1, 0, 32'h20, 0, 32'h1);
      chk("lit_b2b_mis2", 32'(bus_a.misaligned), 32'd1);
      chk("lit_b2b_bad2", bus_a.bad_addr, 32'h21);

      // Reset wins over redirect + stall
      drive(1, 1, 1, 0, 32'h10, 0, 32'h2);
      chk("lit_rr_pc",  bus_a.PC, RV);
      chk("lit_rr_cnt", 32'(bus_a.redirect_cnt), 32'd0);
      chk("lit_rr_mis", 32'(bus_a.misaligned), 32'd0);
      chk("lit_rr_bad", bus_a.bad_addr, 32'd0);
      chk("lit_rr_vd",  32'(bus_a.valid_D), 32'd0);

      for (int i = 0; i < 2000; i++) begin
         logic [31:0] im;
         im = $urandom();
         if ($urandom_range(0, 1) == 1) im[1:0] = 2'b00;
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               $urandom() & 32'hFFFF_FFFC, $urandom(), im);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Parametrised program-counter and fetch-control unit for the pipelined RISC-V core. It generates the fetch PC and computes branch/JAL/JALR targets from the execute stage. It holds the PC on pipeline stalls and flushes the fetch/decode slot on redirect. Misaligned targets are diverted to a trap vector, and redirects are counted for performance monitoring. It sits between the execute-stage branch logic and the instruction memory, and also holds the IF/ID PC register.

## Interface
Parameters:
- XLEN, 32, datapath/PC width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded when a redirect target is misaligned.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hazard unit requests hold of fetch and decode.
- redirect  in  1  execute stage resolved a taken branch, JAL or JALR this cycle.
- jalrsel  in  1  with redirect: 1 = JALR target, 0 = PC-relative target.
- ex_PC  in  XLEN  PC of the instruction in execute.
- base  in  XLEN  rs1 value for JALR.
- ImmOp  in  XLEN  sign-extended immediate of the execute instruction.
- PC  out  XLEN  current fetch PC, drives instruction memory address.
- PC_D  out  XLEN  PC of the instruction held in decode.
- valid_D  out  1  decode slot holds a real instruction (0 = bubble).
- misaligned  out  1  one-cycle pulse: last redirect target was misaligned.
- bad_addr  out  XLEN  offending target, captured with misaligned.
- redirect_cnt  out  CNT_W  saturating count of accepted redirects.

## Operation
- Target computation: when jalrsel=1, target = (base + ImmOp) with bit 0 cleared. When jalrsel=0, target = ex_PC + ImmOp. All sums are modulo 2^XLEN, with no overflow detection.
- Misalignment is target[1:0] != 0, checked after the JALR bit-0 clear, so only bit 1 can fault for JALR.
- Priority per edge, highest first: rst, redirect, stall, normal.
- rst: PC<=RESET_VECTOR, PC_D<=0, valid_D<=0, misaligned<=0, bad_addr<=0, redirect_cnt<=0.
- redirect with an aligned target:
  - PC<=target, valid_D<=0 (flush), PC_D holds.
  - misaligned<=0; redirect_cnt increments.
- redirect with a misaligned target:
  - PC<=TRAP_VECTOR, valid_D<=0.
  - misaligned<=1, bad_addr<=target; redirect_cnt increments.
- stall without redirect: PC, PC_D and valid_D hold; misaligned<=0.
- normal:
  - PC<=PC+4 (wraps 0xFFFF_FFFC -> 0x0000_0000).
  - PC_D<=PC, valid_D<=1, misaligned<=0.
- redirect_cnt saturates at 2^CNT_W-1 and never wraps. bad_addr holds until the next misaligned redirect or reset.
- Redirect overrides a simultaneous stall. Stall is ignored in the cycle redirect is high.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Redirect latency is 1 cycle: the redirect is sampled at edge n, and PC shows the target or trap vector after edge n.
- Flush: the instruction in decode during the redirect edge becomes a bubble. PC_D/valid_D next carry the target on the edge after the redirect, if not stalled.
- misaligned is high for exactly one cycle per faulting redirect. Back-to-back faulting redirects keep it high on consecutive cycles, with bad_addr updated each cycle.
- Reset asserted mid-stream overrides redirect/stall on that edge; the first fetch after release is RESET_VECTOR.
- After reset release with no stall: edge 1 gives PC=RV+4, PC_D=RV, valid_D=1.

## Test plan
- Reset then 4 free-run cycles -> PC = 0x0, 0x4, 0x8, 0xC, 0x10; valid_D=0 on first cycle then 1; PC_D lags PC by one cycle.
- At PC=0x10, stall=1 for 3 cycles, then redirect (jalrsel=0, ex_PC=0xC, ImmOp=0x40) with stall=1 on the same edge -> PC holds 0x10 for 3 cycles, then 0x4C; valid_D=0 on the next cycle; redirect_cnt=1.
- JALR redirect with base=0x1001, ImmOp=0x2 -> target 0x1002 is misaligned. PC=TRAP_VECTOR (0x100), misaligned=1 for one cycle, bad_addr=0x1002. A second JALR with base=0x2001, ImmOp=0x0 gives 0x2000 after the bit-0 clear, with no fault.
- PC=0xFFFF_FFFC, free run -> next PC=0x0000_0000; PC_D=0xFFFF_FFFC.
- With CNT_W=2, 5 consecutive redirects -> redirect_cnt = 1, 2, 3, 3, 3.
- Assert rst during a redirect cycle with stall=1 -> PC=RESET_VECTOR, counters and flags cleared, valid_D=0.
